// File: rtl/univreg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and default width.
// Optional serial outputs are enabled by defining UNIVREG_SERIAL_OUT_EN.
package univreg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } univreg_mode_e;

endpackage

// File: rtl/univreg_cell.sv
// One bit of the universal register: 4:1 next-state mux feeding an async-reset flop.
module univreg_cell
    import univreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       p_bit,
    output logic       q
);

    logic q_d;

    // Any non-decoded sel (X/Z) falls through to hold.
    always_comb begin
        q_d = q;
        case (sel)
            MODE_HOLD: q_d = q;
            MODE_SHR:  q_d = shr_in;
            MODE_SHL:  q_d = shl_in;
            MODE_LOAD: q_d = p_bit;
            default:   q_d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/universal_register.sv
// Universal shift register: hold, shift right, shift left or parallel load each cycle.
// Defining UNIVREG_SERIAL_OUT_EN adds so_right/so_left taps on the end bits.
module universal_register
    import univreg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] p_in,
    input  logic             serial_right,
    input  logic             serial_left,
    output logic [WIDTH-1:0] q
`ifdef UNIVREG_SERIAL_OUT_EN
    ,
    output logic             so_right,
    output logic             so_left
`endif
);

    logic [WIDTH-1:0] q_reg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shr_in;
        logic shl_in;

        // End cells take the serial inputs in place of a missing neighbour.
        if (i == WIDTH - 1) begin : g_msb
            assign shr_in = serial_right;
        end else begin : g_mid_r
            assign shr_in = q_reg[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_in = serial_left;
        end else begin : g_mid_l
            assign shl_in = q_reg[i-1];
        end

        univreg_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel    (sel),
            .shr_in (shr_in),
            .shl_in (shl_in),
            .p_bit  (p_in[i]),
            .q      (q_reg[i])
        );
    end

    assign q = q_reg;

`ifdef UNIVREG_SERIAL_OUT_EN
    assign so_right = q_reg[0];
    assign so_left  = q_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register at WIDTH=4.
module tb_universal_register;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] p_in;
    logic       serial_right;
    logic       serial_left;
    logic [3:0] q;
`ifdef UNIVREG_SERIAL_OUT_EN
    logic       so_right;
    logic       so_left;
`endif

    int vectors;
    int miscompares;

    universal_register #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .p_in         (p_in),
        .serial_right (serial_right),
        .serial_left  (serial_left),
        .q            (q)
`ifdef UNIVREG_SERIAL_OUT_EN
        ,
        .so_right     (so_right),
        .so_left      (so_left)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 2'b00; p_in = 4'b0000; serial_right = 1'b0; serial_left = 1'b0;
        #2;
        vectors++;
        if (q !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_no_clock q=%b expected=%b", q, 4'b0000);
        end
        // Held in reset, a load must not take effect.
        sel = 2'b11; p_in = 4'b1111; serial_right = 1'b1; serial_left = 1'b1;
        tick();
        tick();
        vectors++;
        if (q !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_holds_zero q=%b expected=%b", q, 4'b0000);
        end
    endtask

    task automatic test_load_hold();
        rst = 1'b1; sel = 2'b11; p_in = 4'b1101; serial_right = 1'b0; serial_left = 1'b0;
        tick();
        vectors++;
        if (q !== 4'b1101) begin
            miscompares++;
            $display("FAIL first_edge_load q=%b expected=%b", q, 4'b1101);
        end
        sel = 2'b00; p_in = 4'b0110; serial_right = 1'b1; serial_left = 1'b1;
        tick();
        vectors++;
        if (q !== 4'b1101) begin
            miscompares++;
            $display("FAIL hold q=%b expected=%b", q, 4'b1101);
        end
    endtask

    task automatic test_shift_right_left();
        sel = 2'b01; serial_right = 1'b1; serial_left = 1'b0; p_in = 4'b0000;
        tick();
        vectors++;
        if (q !== 4'b1110) begin
            miscompares++;
            $display("FAIL shift_right q=%b expected=%b", q, 4'b1110);
        end
        sel = 2'b10; serial_left = 1'b1; serial_right = 1'b0;
        tick();
        vectors++;
        if (q !== 4'b1101) begin
            miscompares++;
            $display("FAIL shift_left q=%b expected=%b", q, 4'b1101);
        end
    endtask

    task automatic test_unused_inputs();
        // Shift right from 1101 with serial_left and p_in toggled to irrelevant values.
        sel = 2'b01; serial_right = 1'b0; serial_left = 1'b1; p_in = 4'b1111;
        tick();
        vectors++;
        if (q !== 4'b0110) begin
            miscompares++;
            $display("FAIL shr_ignores_others q=%b expected=%b", q, 4'b0110);
        end
        sel = 2'b10; serial_left = 1'b0; serial_right = 1'b1; p_in = 4'b1111;
        tick();
        vectors++;
        if (q !== 4'b1100) begin
            miscompares++;
            $display("FAIL shl_ignores_others q=%b expected=%b", q, 4'b1100);
        end
    endtask

    task automatic test_shift_out();
        logic [3:0] expect_seq [4];
        expect_seq[0] = 4'b0010;
        expect_seq[1] = 4'b0100;
        expect_seq[2] = 4'b1000;
        expect_seq[3] = 4'b0000;
        sel = 2'b11; p_in = 4'b1001; serial_left = 1'b0; serial_right = 1'b0;
        tick();
        vectors++;
        if (q !== 4'b1001) begin
            miscompares++;
            $display("FAIL load_1001 q=%b expected=%b", q, 4'b1001);
        end
        sel = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (q !== expect_seq[i]) begin
                miscompares++;
                $display("FAIL shl_dropoff step=%0d q=%b expected=%b", i, q, expect_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 2'b11; p_in = 4'b1010;
        tick();
        vectors++;
        if (q !== 4'b1010) begin
            miscompares++;
            $display("FAIL b2b_load_a q=%b expected=%b", q, 4'b1010);
        end
        p_in = 4'b0101;
        tick();
        vectors++;
        if (q !== 4'b0101) begin
            miscompares++;
            $display("FAIL b2b_load_b q=%b expected=%b", q, 4'b0101);
        end
        sel = 2'b01; serial_right = 1'b1;
        tick();
        vectors++;
        if (q !== 4'b1010) begin
            miscompares++;
            $display("FAIL b2b_shr q=%b expected=%b", q, 4'b1010);
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 2'b11; p_in = 4'b1111;
        tick();
        vectors++;
        if (q !== 4'b1111) begin
            miscompares++;
            $display("FAIL load_1111 q=%b expected=%b", q, 4'b1111);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (q !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_immediate q=%b expected=%b", q, 4'b0000);
        end
        tick();
        tick();
        vectors++;
        if (q !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_during_load q=%b expected=%b", q, 4'b0000);
        end
        // Release mid-cycle with load still selected; the next edge loads.
        rst = 1'b1;
        p_in = 4'b0111;
        tick();
        vectors++;
        if (q !== 4'b0111) begin
            miscompares++;
            $display("FAIL load_after_release q=%b expected=%b", q, 4'b0111);
        end
    endtask

`ifdef UNIVREG_SERIAL_OUT_EN
    task automatic test_serial_out();
        sel = 2'b11; p_in = 4'b1101;
        tick();
        vectors++;
        if ({so_left, so_right} !== 2'b11) begin
            miscompares++;
            $display("FAIL so_1101 so_left,so_right=%b expected=%b", {so_left, so_right}, 2'b11);
        end
        sel = 2'b01; serial_right = 1'b0;
        tick();
        vectors++;
        if ({q, so_left, so_right} !== {4'b0110, 2'b00}) begin
            miscompares++;
            $display("FAIL so_after_shr q,so_left,so_right=%b expected=%b",
                     {q, so_left, so_right}, {4'b0110, 2'b00});
        end
        sel = 2'b11; p_in = 4'b1001;
        tick();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({so_left, so_right} !== 2'b00) begin
            miscompares++;
            $display("FAIL so_reset so_left,so_right=%b expected=%b", {so_left, so_right}, 2'b00);
        end
        rst = 1'b1;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load_hold();
        test_shift_right_left();
        test_unused_inputs();
        test_shift_out();
        test_back_to_back();
        test_reset_mid_load();
`ifdef UNIVREG_SERIAL_OUT_EN
        test_serial_out();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port sel, input, 2 bits: mode select (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-005 The block SHALL have port p_in, input, WIDTH bits: parallel load data.
REQ-006 The block SHALL have port serial_right, input, 1 bit: serial data entering the MSB on a right shift.
REQ-007 The block SHALL have port serial_left, input, 1 bit: serial data entering the LSB on a left shift.
REQ-008 The block SHALL have port q, output, WIDTH bits: the register contents, driven directly from flops.

Function
REQ-009 With sel=00 on a rising clk edge, q SHALL keep its value.
REQ-010 With sel=01 on a rising clk edge, q SHALL become {serial_right, q[WIDTH-1:1]}; the old q[0] is discarded.
REQ-011 With sel=10 on a rising clk edge, q SHALL become {q[WIDTH-2:0], serial_left}; the old q[WIDTH-1] is discarded.
REQ-012 With sel=11 on a rising clk edge, q SHALL become p_in.
REQ-013 Latency SHALL be exactly one clock edge from sampled inputs to the q update; there is no handshake and every mode is accepted every cycle.
REQ-014 Serial inputs not used by the selected mode SHALL have no effect; p_in SHALL be ignored unless sel=11.
REQ-015 An X or Z value on sel SHALL be treated as hold in synthesis; simulation may propagate X.
REQ-016 q SHALL be a pure register with no combinational path from any input to q.

Reset
REQ-017 Asserting rst low SHALL set q to all zeros immediately, independent of clk, including mid-shift or mid-load.
REQ-018 While rst is low, q SHALL stay zero regardless of sel and data inputs.
REQ-019 The first rising clk edge after rst goes high SHALL apply the current sel mode normally.

Configuration
REQ-020 Macro UNIVREG_SERIAL_OUT_EN, when defined, SHALL add outputs so_right (= q[0]) and so_left (= q[WIDTH-1]), each 1 bit and combinational from q; both read 0 during reset.
REQ-021 When UNIVREG_SERIAL_OUT_EN is undefined, those ports SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-022 Package univreg_pkg SHALL hold the sel mode encoding as an enum (MODE_HOLD=00, MODE_SHR=01, MODE_SHL=10, MODE_LOAD=11) and the default-width constant.
REQ-023 A per-bit sub-module univreg_cell (4:1 next-state mux plus async-reset flop) SHALL be instantiated WIDTH times by a generate loop; boundary cells take serial_right and serial_left as neighbour inputs.

Verification
REQ-024 rst low with sel=00 and p_in=0000 -> q=0000 without any clock edge.
REQ-025 rst high, sel=11, p_in=1101, one edge -> q=1101; then sel=00 for one edge -> q stays 1101.
REQ-026 From q=1101, sel=01, serial_right=1, one edge -> q=1110; from q=1110, sel=10, serial_left=1, one edge -> q=1101.
REQ-027 From q=1001, four edges of sel=10 with serial_left=0 -> q=0000; the bench also checks the MSB drop-off.
REQ-028 With sel=11 and p_in=1111 loading, assert rst low between edges -> q=0000 at once and stays 0 until release.
REQ-029 With UNIVREG_SERIAL_OUT_EN defined and q=1101 -> so_right=1 and so_left=1; after one right shift with serial_right=0 -> q=0110, so_right=0, so_left=0.
